// File: rtl/pong_pkg.sv
// Shared pong definitions: paddle FSM states and playfield geometry used by
// both the paddle controllers and the renderer.
package pong_pkg;

  localparam int unsigned PONG_POS_W     = 9;
  localparam int unsigned PONG_POS_MIN   = 0;
  localparam int unsigned PONG_POS_MAX   = 504;
  localparam int unsigned PONG_RESET_POS = 252;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_L = 2'd1,
    MOVE_R = 2'd2,
    BOTH   = 2'd3
  } paddle_state_e;

  // Direction arbitration from the debounced key levels.
  function automatic paddle_state_e key_state(input logic l, input logic r);
    paddle_state_e s;
    case ({l, r})
      2'b10:   s = MOVE_L;
      2'b01:   s = MOVE_R;
      2'b11:   s = BOTH;
      default: s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key input stage: 2-flop synchroniser, polarity normalisation and
// stable-level debounce. Exposes only the debounced pressed level.
module key_debounce #(
  parameter int unsigned DEB_CYCLES     = 250000,
  parameter int unsigned KEY_ACTIVE_LOW = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic key_db
);

  localparam int unsigned CNT_W   = $clog2(DEB_CYCLES + 1);
  localparam logic        ACT_LOW = (KEY_ACTIVE_LOW != 0);

  logic             sync1_q;
  logic             sync2_q;
  logic             pressed;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;

  assign pressed = sync2_q ^ ACT_LOW;
  assign key_db  = stable_q;

  // Flip the stable level only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (pressed == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= ACT_LOW;
      sync2_q  <= ACT_LOW;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= key;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Per-player paddle controller: debounced keys drive a saturating, frame-
// synchronised paddle offset. Optional macro PADDLE_ACCEL_EN doubles the step
// after four consecutive ticks in the same move direction.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 250000,
  parameter int unsigned POS_W          = PONG_POS_W,
  parameter int unsigned STEP           = 8,
  parameter int unsigned POS_MIN        = PONG_POS_MIN,
  parameter int unsigned POS_MAX        = PONG_POS_MAX,
  parameter int unsigned RESET_POS      = PONG_RESET_POS,
  parameter int unsigned KEY_ACTIVE_LOW = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             left_key,
  input  logic             right_key,
  input  logic             frame_tick,
  output logic [POS_W-1:0] bar,
  output logic             moving,
  output logic             dir,
  output logic             left_db,
  output logic             right_db
);

  localparam int unsigned EXT_W = POS_W + 1;
  localparam logic [EXT_W-1:0] STEP_X = EXT_W'(STEP);
  localparam logic [EXT_W-1:0] MIN_X  = EXT_W'(POS_MIN);
  localparam logic [EXT_W-1:0] MAX_X  = EXT_W'(POS_MAX);

  paddle_state_e    state_q;
  paddle_state_e    state_d;
  logic [POS_W-1:0] bar_q;
  logic [POS_W-1:0] bar_d;
  logic [POS_W-1:0] bar_new;
  logic             moving_q;
  logic             moving_d;
  logic             dir_q;
  logic             dir_d;
  logic [EXT_W-1:0] step_x;
  logic [EXT_W-1:0] bar_x;
  logic [EXT_W-1:0] up_x;

  key_debounce #(
    .DEB_CYCLES     (DEB_CYCLES),
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_left_db (
    .clock  (clock),
    .reset  (reset),
    .key    (left_key),
    .key_db (left_db)
  );

  key_debounce #(
    .DEB_CYCLES     (DEB_CYCLES),
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_right_db (
    .clock  (clock),
    .reset  (reset),
    .key    (right_key),
    .key_db (right_db)
  );

  assign bar    = bar_q;
  assign moving = moving_q;
  assign dir    = dir_q;

  always_comb begin
    state_d = key_state(left_db, right_db);
  end

`ifdef PADDLE_ACCEL_EN
  localparam logic [EXT_W-1:0] STEP2_X = EXT_W'(2 * STEP);

  logic [2:0] hold_q;
  logic [2:0] hold_d;

  // Ticks spent in one move direction; any direction change restarts it.
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q) begin
      hold_d = 3'd0;
    end else if (frame_tick && (state_q == MOVE_L || state_q == MOVE_R) &&
                 hold_q != 3'd7) begin
      hold_d = hold_q + 3'd1;
    end
    step_x = (hold_q >= 3'd4) ? STEP2_X : STEP_X;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q <= 3'd0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  always_comb begin
    step_x = STEP_X;
  end
`endif

  // Saturating move computed one bit wider than bar so nothing wraps.
  always_comb begin
    bar_x   = {1'b0, bar_q};
    up_x    = bar_x + step_x;
    bar_new = bar_q;
    case (state_q)
      MOVE_L:  bar_new = (up_x > MAX_X) ? POS_W'(POS_MAX) : up_x[POS_W-1:0];
      MOVE_R:  bar_new = (bar_x < MIN_X + step_x) ? POS_W'(POS_MIN)
                                                  : POS_W'(bar_x - step_x);
      default: bar_new = bar_q;
    endcase

    bar_d    = bar_q;
    moving_d = moving_q;
    dir_d    = dir_q;
    if (frame_tick) begin
      bar_d    = bar_new;
      moving_d = (bar_new != bar_q);
      if (bar_new != bar_q) begin
        dir_d = (bar_new < bar_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      bar_q    <= POS_W'(RESET_POS);
      moving_q <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bar_q    <= bar_d;
      moving_q <= moving_d;
      dir_q    <= dir_d;
    end
  end

endmodule
